// File: rtl/video_capture_buf.sv
// Snapshot buffer for a burst of 12-bit video samples, drained as a 2*N byte message.
// Optional macro VCAP_TRIGGER_EN: capture waits for a rising edge of hd while armed.
module video_capture_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_ena,
    input  logic [11:0] sample_data,
    input  logic        sample_valid,
    input  logic        hd,
    input  logic        rdreq,
    output logic [7:0]  out_data,
    output logic        have_msg,
    output logic [7:0]  len,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_READY   = 2'd3;
    localparam logic [7:0] DEPTH_B    = 8'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    // High byte of a sample first (zero-extended), then the low byte.
    function automatic logic [7:0] sample_byte(input logic [11:0] s, input logic lo);
        logic [7:0] b;
        if (lo == 1'b0) begin
            b = {4'b0000, s[11:8]};
        end else begin
            b = s[7:0];
        end
        return b;
    endfunction

    logic [1:0]    r_state;
    logic [7:0]    r_n;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic          r_bsel;
    logic          r_have_msg;
    logic [7:0]    r_len;
    logic [11:0]   r_mem [DEPTH];

    logic          w_abort;
    logic [7:0]    w_cmd_n;
    logic          w_wr;
    logic          w_last_wr;
    logic          w_pop;
    logic          w_last_pop;
    logic          w_arm_go;
    logic [11:0]   w_rd_sample;

    assign w_abort     = in_ena && (in_data == 8'h00);
    assign w_cmd_n     = (in_data > DEPTH_B) ? DEPTH_B : in_data;
    assign w_wr        = (r_state == ST_CAPTURE) && sample_valid;
    assign w_last_wr   = w_wr && (8'(r_wptr) == (r_n - 8'd1));
    assign w_pop       = r_have_msg && rdreq;
    assign w_last_pop  = w_pop && r_bsel && (8'(r_rptr) == (r_n - 8'd1));
    assign w_rd_sample = r_mem[r_rptr];

`ifdef VCAP_TRIGGER_EN
    logic r_hd_q;

    // Delayed copy of hd for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hd_q <= 1'b0;
        end else begin
            r_hd_q <= hd;
        end
    end

    assign w_arm_go = hd & ~r_hd_q;
`else
    logic w_unused_hd;
    assign w_unused_hd = hd;
    assign w_arm_go    = 1'b1;
`endif

    // Sample storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= sample_data;
        end
    end

    // Control FSM, pointers and message registers; abort overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_n        <= 8'h00;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_bsel     <= 1'b0;
            r_have_msg <= 1'b0;
            r_len      <= 8'h00;
        end else if (w_abort) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_bsel     <= 1'b0;
            r_have_msg <= 1'b0;
            r_len      <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_ena) begin
                        r_n     <= w_cmd_n;
                        r_wptr  <= '0;
                        r_rptr  <= '0;
                        r_bsel  <= 1'b0;
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_arm_go) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_wr) begin
                        r_wptr <= r_wptr + PTR_ONE;
                        if (w_last_wr) begin
                            r_state    <= ST_READY;
                            r_have_msg <= 1'b1;
                            r_len      <= {r_n[6:0], 1'b0};
                        end
                    end
                end
                ST_READY: begin
                    if (w_last_pop) begin
                        r_state    <= ST_IDLE;
                        r_have_msg <= 1'b0;
                        r_len      <= 8'h00;
                        r_bsel     <= 1'b0;
                        r_rptr     <= '0;
                    end else if (w_pop) begin
                        if (r_bsel) begin
                            r_bsel <= 1'b0;
                            r_rptr <= r_rptr + PTR_ONE;
                        end else begin
                            r_bsel <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data = r_have_msg ? sample_byte(w_rd_sample, r_bsel) : 8'h00;
    assign have_msg = r_have_msg;
    assign len      = r_len;
    assign busy     = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);

endmodule
